// File: rtl/adbg_jsp_host_if.sv
// adbg_jsp_host_if: command, byte-stream and serial-port bridge signals of the JSP host engine.
interface adbg_jsp_host_if;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic       cmd_write_i;
    logic [3:0] cmd_len_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic [7:0] jsp_data_o;
    logic       jsp_wr_strobe_o;
    logic [7:0] jsp_data_i;
    logic       jsp_rd_strobe_o;
    logic [3:0] jsp_bytes_free_i;
    logic [3:0] jsp_bytes_available_i;
    logic       done_o;
    logic [3:0] remaining_o;

    modport slave (
        input  cmd_valid_i, cmd_write_i, cmd_len_i, tx_data_i, tx_valid_i, rx_ready_i,
               jsp_data_i, jsp_bytes_free_i, jsp_bytes_available_i,
        output cmd_ready_o, tx_ready_o, rx_data_o, rx_valid_o, jsp_data_o, jsp_wr_strobe_o,
               jsp_rd_strobe_o, done_o, remaining_o
    );

    modport master (
        output cmd_valid_i, cmd_write_i, cmd_len_i, tx_data_i, tx_valid_i, rx_ready_i,
               jsp_data_i, jsp_bytes_free_i, jsp_bytes_available_i,
        input  cmd_ready_o, tx_ready_o, rx_data_o, rx_valid_o, jsp_data_o, jsp_wr_strobe_o,
               jsp_rd_strobe_o, done_o, remaining_o
    );
endinterface

// File: rtl/adbg_jsp_host.sv
// adbg_jsp_host: paces byte transfers to/from the JSP bridge so strobes stay SYNC_WAIT cycles apart.
module adbg_jsp_host #(
    parameter int unsigned SYNC_WAIT = 4
) (
    input logic             tck_i,
    input logic             rst_ni,
    adbg_jsp_host_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SAMPLE, XFER, GAP, DONE} state_e;

    localparam logic [3:0] GAP_LAST = 4'(SYNC_WAIT - 2);

    state_e     state_q, state_d;
    logic       write_q, write_d;
    logic [3:0] credit_q, credit_d;
    logic [3:0] remaining_q, remaining_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       done_q, done_d;
    logic       can, wr_stb, rd_stb;
    logic [3:0] sampled;

    assign can     = credit_q != 4'd0 && remaining_q != 4'd0;
    assign wr_stb  = state_q == XFER && write_q && can && bus.tx_valid_i;
    assign rd_stb  = state_q == XFER && !write_q && can && bus.rx_ready_i;
    assign sampled = write_q ? bus.jsp_bytes_free_i : bus.jsp_bytes_available_i;

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        credit_d    = credit_q;
        remaining_d = remaining_q;
        cnt_d       = 4'd0;
        data_d      = data_q;
        rx_data_d   = rx_data_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: if (bus.cmd_valid_i) begin
                write_d     = bus.cmd_write_i;
                remaining_d = bus.cmd_len_i;
                state_d     = bus.cmd_len_i == 4'd0 ? DONE : SAMPLE;
            end
            SAMPLE: begin
                // the bridge FIFO is 8 deep, so larger readings are stale or bogus
                credit_d = sampled > 4'd8 ? 4'd8 : sampled;
                state_d  = credit_d != 4'd0 ? XFER : GAP;
            end
            XFER: if (wr_stb || rd_stb) begin
                credit_d    = credit_q - 4'd1;
                remaining_d = remaining_q - 4'd1;
                data_d      = wr_stb ? bus.tx_data_i : data_q;
                state_d     = GAP;
            end else if (!can) begin
                state_d = GAP;
            end
            GAP: if (cnt_q == GAP_LAST) begin
                state_d = remaining_q == 4'd0 ? DONE : credit_q != 4'd0 ? XFER : SAMPLE;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // capture the FIFO head once, when a read byte is offered
        if (state_d == XFER && state_q != XFER && !write_q) rx_data_d = bus.jsp_data_i;
    end

    always_ff @(posedge tck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            credit_q    <= 4'd0;
            remaining_q <= 4'd0;
            cnt_q       <= 4'd0;
            data_q      <= 8'd0;
            rx_data_q   <= 8'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            credit_q    <= credit_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            rx_data_q   <= rx_data_d;
            done_q      <= done_d;
        end
    end

    assign bus.cmd_ready_o     = state_q == IDLE;
    assign bus.tx_ready_o      = state_q == XFER && write_q;
    assign bus.rx_valid_o      = state_q == XFER && !write_q;
    assign bus.rx_data_o       = rx_data_q;
    assign bus.jsp_wr_strobe_o = wr_stb;
    assign bus.jsp_rd_strobe_o = rd_stb;
    assign bus.jsp_data_o      = wr_stb ? bus.tx_data_i : data_q;
    assign bus.done_o          = done_q;
    assign bus.remaining_o     = remaining_q;
endmodule

// File: tb/tb_adbg_jsp_host.sv
// tb_adbg_jsp_host: table, directed and random command runs against a transaction-level bridge model.
module tb_adbg_jsp_host;
    localparam int SW = 4;

    logic tck_i = 1'b0;
    logic rst_ni = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 tck_i = ~tck_i;

    adbg_jsp_host_if bus ();

    adbg_jsp_host #(.SYNC_WAIT(SW)) dut (
        .tck_i  (tck_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    typedef struct {
        bit wr;
        int len;
        int cnt;
        int exp_k;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // mode 0 constant counter, 1 free 2->8 at cycle 6, 2 avail 0 for 40 cycles,
    // 3 tx_valid dropped 10 cycles after first byte, 4 random counters and stalls
    task automatic run_cmd(input bit wr, input int len, input int cnt, input int mode, input int exp_k);
        logic [7:0] src[16];
        logic [7:0] rdq[16];
        int nstb = 0, ndone = 0, k = -1, last = -1, s1 = -1, c;
        bit v, ws, rs, done_seen = 0;
        for (int i = 0; i < 16; i++) begin
            src[i] = 8'($urandom_range(0, 255));
            rdq[i] = 8'($urandom_range(0, 255));
        end
        src[0] = 8'h41; src[1] = 8'h42; src[2] = 8'h43;
        rdq[0] = 8'h5A; rdq[1] = 8'h5B;
        @(posedge tck_i); #1;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = wr;
        bus.cmd_len_i   = 4'(len);
        @(negedge tck_i);
        chk("ready_idle", bus.cmd_ready_o, 1);
        for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
            @(posedge tck_i); #1;
            bus.cmd_valid_i = 1'b0;
            c = mode == 1 ? (cyc < 6 ? 2 : 8) : mode == 2 ? (cyc < 40 ? 0 : 1) :
                mode == 4 ? ($urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(1, 15))) : cnt;
            v = mode == 3 ? !(s1 >= 0 && cyc > s1 && cyc <= s1 + 10) :
                mode == 4 ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.jsp_bytes_free_i      = wr ? 4'(c) : 4'(15 - c);
            bus.jsp_bytes_available_i = wr ? 4'(15 - c) : 4'(c);
            bus.tx_valid_i = v;
            bus.rx_ready_i = v;
            bus.tx_data_i  = src[nstb];
            bus.jsp_data_i = rdq[nstb];
            @(negedge tck_i);
            ws = bus.jsp_wr_strobe_o;
            rs = bus.jsp_rd_strobe_o;
            chk("remaining", bus.remaining_o, len - nstb);
            if (!bus.done_o) chk("ready_busy", bus.cmd_ready_o, 0);
            chk(wr ? "rx_valid_on_write" : "tx_ready_on_read", wr ? bus.rx_valid_o : bus.tx_ready_o, 0);
            chk("wrong_dir_strobe", wr ? rs : ws, 0);
            if (ws || rs) begin
                chk("stb_handshake", wr ? bus.tx_valid_i : bus.rx_ready_i, 1);
                chk("stb_offer", wr ? bus.tx_ready_o : bus.rx_valid_o, 1);
                if (mode == 2) chk("early_rd_strobe", int'(cyc >= 40), 1);
                if (last >= 0) chk("spacing_ge_sw", int'(cyc - last >= SW), 1);
                if (wr) chk("wr_byte", bus.jsp_data_o, src[nstb]);
                else chk("rx_byte", bus.rx_data_o, rdq[nstb]);
                last = cyc;
                if (s1 < 0) s1 = cyc;
                nstb++;
            end else if (wr && nstb > 0) begin
                chk("wr_data_hold", bus.jsp_data_o, src[nstb - 1]);
            end
            if (bus.done_o) begin
                ndone++;
                k = cyc;
                done_seen = 1;
            end
        end
        chk("done_seen", done_seen, 1);
        if (done_seen && exp_k >= 0) chk("done_latency", k, exp_k);
        chk("strobe_count", nstb, len);
        repeat (2) begin
            @(posedge tck_i); #1;
            @(negedge tck_i);
            if (bus.done_o) ndone++;
            chk("post_strobe", bus.jsp_wr_strobe_o | bus.jsp_rd_strobe_o, 0);
            chk("post_ready", bus.cmd_ready_o, 1);
        end
        chk("done_count", ndone, 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", bus.cmd_ready_o, 1);
        chk("rst_remaining", bus.remaining_o, 0);
        chk("rst_jsp_data", bus.jsp_data_o, 0);
        chk("rst_rx_data", bus.rx_data_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_wr_strobe", bus.jsp_wr_strobe_o, 0);
        chk("rst_rd_strobe", bus.jsp_rd_strobe_o, 0);
        chk("rst_tx_ready", bus.tx_ready_o, 0);
        chk("rst_rx_valid", bus.rx_valid_o, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid_i = 0; bus.cmd_write_i = 0; bus.cmd_len_i = 0;
        bus.tx_data_i = 0; bus.tx_valid_i = 0; bus.rx_ready_i = 0; bus.jsp_data_i = 0;
        bus.jsp_bytes_free_i = 0; bus.jsp_bytes_available_i = 0;
        tbl[0] = '{1, 3, 8, 14};
        tbl[1] = '{1, 1, 15, 6};
        tbl[2] = '{1, 5, 2, 24};
        tbl[3] = '{0, 2, 2, 10};
        tbl[4] = '{0, 4, 1, 21};
        tbl[5] = '{1, 0, 8, 1};
        tbl[6] = '{0, 15, 12, 63};
        tbl[7] = '{1, 7, 3, 32};
        repeat (3) @(negedge tck_i);
        chk_reset_vals();
        @(posedge tck_i); #1 rst_ni = 1'b1;
        @(negedge tck_i);
        chk_reset_vals();

        foreach (tbl[i]) run_cmd(tbl[i].wr, tbl[i].len, tbl[i].cnt, 0, tbl[i].exp_k);
        run_cmd(1, 5, 0, 1, 23);
        run_cmd(0, 1, 0, 2, 46);
        run_cmd(1, 2, 8, 3, 17);
        run_cmd(0, 0, 0, 0, 1);
        for (int i = 0; i < 30; i++)
            run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 0, 4, -1);

        // reset in the middle of a write aborts it silently
        @(posedge tck_i); #1;
        bus.cmd_valid_i = 1; bus.cmd_write_i = 1; bus.cmd_len_i = 4'd5;
        bus.jsp_bytes_free_i = 4'd8; bus.tx_valid_i = 1; bus.tx_data_i = 8'hC3;
        repeat (8) @(posedge tck_i);
        #1 rst_ni = 1'b0;
        bus.cmd_valid_i = 0;
        @(negedge tck_i);
        chk_reset_vals();
        @(posedge tck_i); #1 rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge tck_i);
            chk("abort_done", bus.done_o, 0);
            chk("abort_strobe", bus.jsp_wr_strobe_o | bus.jsp_rd_strobe_o, 0);
            chk("abort_ready", bus.cmd_ready_o, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
